// File: rtl/ex_iter_alu_pkg.sv
// rtl/ex_iter_alu_pkg.sv - op codes and FSM states shared by the iterative execute unit.
package lc3b_types;

   typedef enum logic [3:0] {
      ADD   = 4'd0,
      AND   = 4'd1,
      NOT   = 4'd2,
      LSHF  = 4'd3,
      RSHFL = 4'd4,
      RSHFA = 4'd5,
      PASSA = 4'd6,
      PASSB = 4'd7,
      MUL   = 4'd8,
      DIVU  = 4'd9,
      REMU  = 4'd10
   } ex_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } ex_iter_state_t;

endpackage

// File: rtl/iter_shift_core.sv
// rtl/iter_shift_core.sv - shared shift-add multiply / restoring divide datapath.
// The divide step is only built when EX_ITER_DIV_EN is defined.
module iter_shift_core #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic             step,
`ifdef EX_ITER_DIV_EN
   input  logic             div_mode,
   input  logic             sel_quot,
`endif
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] res_nx
);

   // acc: product / partial remainder; aux: multiplicand / dividend->quotient; opnd: multiplier / divisor
   logic [WIDTH-1:0] acc_q, acc_d, acc_stp;
   logic [WIDTH-1:0] aux_q, aux_d, aux_stp;
   logic [WIDTH-1:0] opnd_q, opnd_d, opnd_stp;
`ifdef EX_ITER_DIV_EN
   logic [WIDTH:0]   trial;
`endif

   always_comb begin
      acc_stp  = acc_q + (opnd_q[0] ? aux_q : '0);
      aux_stp  = aux_q << 1;
      opnd_stp = opnd_q >> 1;
      res_nx   = acc_stp;
`ifdef EX_ITER_DIV_EN
      // The trial MSB is a borrow: partial remainder stays below the divisor.
      trial = {acc_q, aux_q[WIDTH-1]} - {1'b0, opnd_q};
      if (div_mode) begin
         opnd_stp = opnd_q;
         if (!trial[WIDTH]) begin
            acc_stp = trial[WIDTH-1:0];
            aux_stp = {aux_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_stp = {acc_q[WIDTH-2:0], aux_q[WIDTH-1]};
            aux_stp = {aux_q[WIDTH-2:0], 1'b0};
         end
         res_nx = sel_quot ? aux_stp : acc_stp;
      end
`endif
   end

   always_comb begin
      acc_d  = acc_q;
      aux_d  = aux_q;
      opnd_d = opnd_q;
      if (clr) begin
         acc_d  = '0;
         aux_d  = '0;
         opnd_d = '0;
      end else if (load) begin
         acc_d  = '0;
         aux_d  = a_in;
         opnd_d = b_in;
      end else if (step) begin
         acc_d  = acc_stp;
         aux_d  = aux_stp;
         opnd_d = opnd_stp;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         aux_q  <= '0;
         opnd_q <= '0;
      end else begin
         acc_q  <= acc_d;
         aux_q  <= aux_d;
         opnd_q <= opnd_d;
      end
   end

endmodule

// File: rtl/ex_iter_alu.sv
// rtl/ex_iter_alu.sv - multi-cycle EX stage: 1-cycle ALU ops, iterative MUL and DIVU/REMU.
// DIVU/REMU are iterative only with EX_ITER_DIV_EN; otherwise they flag div_zero after 1 cycle.
module ex_iter_alu
   import lc3b_types::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             div_zero
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int SH_W  = $clog2(WIDTH);

   ex_iter_state_t   state_q, state_d;
   logic [CNT_W-1:0] counter_q, counter_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             div_zero_q, div_zero_d;
`ifdef EX_ITER_DIV_EN
   logic             div_mode_q, div_mode_d;
   logic             quot_q, quot_d;
`endif

   ex_op_t           op_e;
   logic [SH_W-1:0]  sh;
   logic             accept;
   logic             core_clr, core_load, core_step;
   logic [WIDTH-1:0] core_res;

   assign op_e      = ex_op_t'(op);
   assign sh        = b[SH_W-1:0];
   assign in_ready  = !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign div_zero  = div_zero_q;

   always_comb begin
      state_d    = state_q;
      counter_d  = counter_q;
      result_d   = result_q;
      div_zero_d = div_zero_q;
      core_clr   = 1'b0;
      core_load  = 1'b0;
      core_step  = 1'b0;
`ifdef EX_ITER_DIV_EN
      div_mode_d = div_mode_q;
      quot_d     = quot_q;
`endif
      if (flush) begin
         state_d    = IDLE;
         counter_d  = '0;
         result_d   = '0;
         div_zero_d = 1'b0;
         core_clr   = 1'b1;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if ((state_q == DONE) && out_ready) state_d = IDLE;
               if (accept) begin
                  state_d    = DONE;
                  div_zero_d = 1'b0;
                  case (op_e)
                     ADD:   result_d = a + b;
                     AND:   result_d = a & b;
                     NOT:   result_d = ~a;
                     LSHF:  result_d = a << sh;
                     RSHFL: result_d = a >> sh;
                     RSHFA: result_d = $signed(a) >>> sh;
                     PASSA: result_d = a;
                     PASSB: result_d = b;
                     MUL: begin
                        state_d   = BUSY;
                        counter_d = CNT_W'(WIDTH);
                        core_load = 1'b1;
`ifdef EX_ITER_DIV_EN
                        div_mode_d = 1'b0;
`endif
                     end
                     DIVU, REMU: begin
`ifdef EX_ITER_DIV_EN
                        if (b == '0) begin
                           result_d   = (op_e == DIVU) ? '1 : a;
                           div_zero_d = 1'b1;
                        end else begin
                           state_d    = BUSY;
                           counter_d  = CNT_W'(WIDTH);
                           core_load  = 1'b1;
                           div_mode_d = 1'b1;
                           quot_d     = (op_e == DIVU);
                        end
`else
                        result_d   = '0;
                        div_zero_d = 1'b1;
`endif
                     end
                     default: result_d = '0;
                  endcase
               end
            end
            BUSY: begin
               core_step = 1'b1;
               counter_d = counter_q - CNT_W'(1);
               // The last step's combinational output is the final answer.
               if (counter_q == CNT_W'(1)) begin
                  state_d    = DONE;
                  result_d   = core_res;
                  div_zero_d = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         counter_q  <= '0;
         result_q   <= '0;
         div_zero_q <= 1'b0;
`ifdef EX_ITER_DIV_EN
         div_mode_q <= 1'b0;
         quot_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         counter_q  <= counter_d;
         result_q   <= result_d;
         div_zero_q <= div_zero_d;
`ifdef EX_ITER_DIV_EN
         div_mode_q <= div_mode_d;
         quot_q     <= quot_d;
`endif
      end
   end

   iter_shift_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk      (clk),
      .rst_n    (reset_n),
      .clr      (core_clr),
      .load     (core_load),
      .step     (core_step),
`ifdef EX_ITER_DIV_EN
      .div_mode (div_mode_d),
      .sel_quot (quot_q),
`endif
      .a_in     (a),
      .b_in     (b),
      .res_nx   (core_res)
   );

endmodule

// File: tb/tb_ex_iter_alu.sv
// tb/tb_ex_iter_alu.sv - scoreboard bench for ex_iter_alu at WIDTH=16.
// Expectations follow EX_ITER_DIV_EN the same way the design does.
module tb_ex_iter_alu;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic        div_zero;

   typedef struct {
      logic [15:0] res;
      logic        dz;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   ex_iter_alu #(.WIDTH(16)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .div_zero  (div_zero)
   );

   // Reference model: result, div_zero flag and accept-to-valid latency.
   function automatic void model(input logic [3:0] mop, input logic [15:0] ma, input logic [15:0] mb,
                                 output logic [15:0] r, output logic dz, output int lat);
      logic [31:0] prod;
      dz  = 1'b0;
      lat = 1;
      r   = 16'h0000;
      case (mop)
         4'd0: r = ma + mb;
         4'd1: r = ma & mb;
         4'd2: r = ~ma;
         4'd3: r = ma << mb[3:0];
         4'd4: r = ma >> mb[3:0];
         4'd5: r = $signed(ma) >>> mb[3:0];
         4'd6: r = ma;
         4'd7: r = mb;
         4'd8: begin prod = ma * mb; r = prod[15:0]; lat = 17; end
         4'd9, 4'd10: begin
`ifdef EX_ITER_DIV_EN
            if (mb == 16'h0000) begin
               r  = (mop == 4'd9) ? 16'hFFFF : ma;
               dz = 1'b1;
            end else begin
               r   = (mop == 4'd9) ? ma / mb : ma % mb;
               lat = 17;
            end
`else
            dz = 1'b1;
`endif
         end
         default: r = 16'h0000;
      endcase
   endfunction

   task automatic drive(input logic [3:0] dop, input logic [15:0] da, input logic [15:0] db);
      in_valid = 1'b1;
      op       = dop;
      a        = da;
      b        = db;
   endtask

   // Counts negedges after the accepting edge until out_valid; -1 on timeout.
   task automatic wait_valid(input int limit, output int cyc, output bit saw_ready);
      cyc       = -1;
      saw_ready = 1'b0;
      for (int k = 1; k <= limit; k++) begin
         @(negedge clk);
         if (out_valid) begin
            cyc = k;
            break;
         end
         if (in_ready) saw_ready = 1'b1;
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op = 4'd0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || result !== 16'h0000 || div_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b result=%h dz=%b, want 0/0000/0", out_valid, result, div_zero);
      end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_add_back_to_back;
      logic [15:0] av[3] = '{16'h7FFF, 16'h1234, 16'hFFFF};
      logic [15:0] bv[3] = '{16'h0001, 16'h1111, 16'h0002};
      logic [15:0] ev[3] = '{16'h8000, 16'h2345, 16'h0001};
      exp_t e;
      @(negedge clk);
      out_ready = 1'b1;
      drive(4'd0, av[0], bv[0]);
      sbq.push_back('{ev[0], 1'b0});
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         if (i < 2) begin
            drive(4'd0, av[i+1], bv[i+1]);
            sbq.push_back('{ev[i+1], 1'b0});
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         e = sbq.pop_front();
         checks++;
         if (out_valid !== 1'b1 || result !== e.res || div_zero !== e.dz) begin
            errors++;
            $display("FAIL add_b2b[%0d]: got valid=%b result=%h dz=%b, want 1/%h/%b", i, out_valid, result, div_zero, e.res, e.dz);
         end
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_b2b_ready[%0d]: got in_ready=%b, want 1", i, in_ready);
         end
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_drain: got out_valid=%b, want 0", out_valid);
      end
   endtask

   task automatic test_mul;
      int cyc;
      bit rdy;
      exp_t e;
      @(negedge clk);
      out_ready = 1'b1;
      drive(4'd8, 16'h0012, 16'h0034);
      sbq.push_back('{16'h03A8, 1'b0});
      @(posedge clk);
      #1;
      drive(4'd0, 16'hAAAA, 16'h5555);
      in_valid = 1'b0;
      wait_valid(40, cyc, rdy);
      checks++;
      if (cyc !== 17) begin
         errors++;
         $display("FAIL mul_latency: got %0d cycles, want 17", cyc);
      end
      checks++;
      if (rdy !== 1'b0) begin
         errors++;
         $display("FAIL mul_busy_ready: in_ready seen=%b during BUSY, want 0", rdy);
      end
      e = sbq.pop_front();
      checks++;
      if (result !== e.res || div_zero !== e.dz) begin
         errors++;
         $display("FAIL mul_result: got %h dz=%b, want %h dz=%b", result, div_zero, e.res, e.dz);
      end
   endtask

   task automatic test_op_sweep;
      logic [3:0]  t_op[12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd12, 4'd8, 4'd8, 4'd3, 4'd15};
      logic [15:0] t_a[12]  = '{16'hF0F0, 16'h00FF, 16'h0001, 16'h8000, 16'h7F00, 16'hBEEF,
                                16'h1111, 16'hFFFF, 16'hFFFD, 16'hFFFF, 16'h00F1, 16'h1234};
      logic [15:0] t_b[12]  = '{16'h3C3C, 16'h1234, 16'h000F, 16'h0003, 16'h0018, 16'h0000,
                                16'hCAFE, 16'hFFFF, 16'h0005, 16'hFFFF, 16'h0013, 16'h5678};
      logic [15:0] r;
      logic        dz;
      int          lat;
      int          cyc;
      bit          rdy;
      exp_t        e;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         out_ready = 1'b1;
         drive(t_op[i], t_a[i], t_b[i]);
         model(t_op[i], t_a[i], t_b[i], r, dz, lat);
         sbq.push_back('{r, dz});
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         wait_valid(40, cyc, rdy);
         checks++;
         if (cyc !== lat) begin
            errors++;
            $display("FAIL sweep_latency[%0d] op=%0d: got %0d, want %0d", i, t_op[i], cyc, lat);
         end
         e = sbq.pop_front();
         checks++;
         if (result !== e.res || div_zero !== e.dz) begin
            errors++;
            $display("FAIL sweep_result[%0d] op=%0d: got %h dz=%b, want %h dz=%b", i, t_op[i], result, div_zero, e.res, e.dz);
         end
      end
   endtask

   task automatic test_div;
      logic [3:0]  d_op[5] = '{4'd9, 4'd10, 4'd9, 4'd10, 4'd9};
      logic [15:0] d_a[5]  = '{16'd100, 16'd100, 16'h1234, 16'h1234, 16'hFFFF};
      logic [15:0] d_b[5]  = '{16'd7, 16'd7, 16'h0000, 16'h0000, 16'h0001};
`ifdef EX_ITER_DIV_EN
      logic [15:0] d_r[5]  = '{16'd14, 16'd2, 16'hFFFF, 16'h1234, 16'hFFFF};
      logic        d_z[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      int          d_l[5]  = '{17, 17, 1, 1, 17};
`else
      logic [15:0] d_r[5]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      logic        d_z[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      int          d_l[5]  = '{1, 1, 1, 1, 1};
`endif
      int   cyc;
      bit   rdy;
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         out_ready = 1'b1;
         drive(d_op[i], d_a[i], d_b[i]);
         sbq.push_back('{d_r[i], d_z[i]});
         @(posedge clk);
         #1;
         drive(4'd0, 16'h0000, 16'h0000);
         in_valid = 1'b0;
         wait_valid(40, cyc, rdy);
         checks++;
         if (cyc !== d_l[i]) begin
            errors++;
            $display("FAIL div_latency[%0d]: got %0d, want %0d", i, cyc, d_l[i]);
         end
         e = sbq.pop_front();
         checks++;
         if (result !== e.res || div_zero !== e.dz) begin
            errors++;
            $display("FAIL div_result[%0d]: got %h dz=%b, want %h dz=%b", i, result, div_zero, e.res, e.dz);
         end
      end
   endtask

   task automatic test_rshfa_hold;
      exp_t e;
      @(negedge clk);
      out_ready = 1'b0;
      drive(4'd5, 16'h8010, 16'h0004);
      sbq.push_back('{16'hF801, 1'b0});
      @(posedge clk);
      #1;
      drive(4'd0, 16'h0001, 16'h0001);
      e = sbq.pop_front();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || result !== e.res || div_zero !== e.dz || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold[%0d]: got valid=%b result=%h dz=%b in_ready=%b, want 1/%h/%b/0",
                     i, out_valid, result, div_zero, in_ready, e.res, e.dz);
         end
      end
      out_ready = 1'b1;
      sbq.push_back('{16'h0002, 1'b0});
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL hold_release_ready: got in_ready=%b, want 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (out_valid !== 1'b1 || result !== e.res) begin
         errors++;
         $display("FAIL hold_next_op: got valid=%b result=%h, want 1/%h", out_valid, result, e.res);
      end
   endtask

   task automatic test_flush;
      int   cyc;
      bit   rdy;
      bit   seen;
      exp_t e;
      @(negedge clk);
      out_ready = 1'b1;
      drive(4'd8, 16'h0055, 16'h0003);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      drive(4'd0, 16'h0009, 16'h0009);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_ready: got in_ready=%b during flush, want 0", in_ready);
      end
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_idle: got valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
      end
      seen = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL flush_no_result: out_valid seen=%b after flush, want 0", seen);
      end
      @(negedge clk);
      drive(4'd0, 16'd3, 16'd4);
      sbq.push_back('{16'd7, 1'b0});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_valid(10, cyc, rdy);
      e = sbq.pop_front();
      checks++;
      if (cyc !== 1 || result !== e.res) begin
         errors++;
         $display("FAIL flush_then_add: got %0d cycles result=%h, want 1/%h", cyc, result, e.res);
      end
   endtask

   task automatic test_async_reset;
      int          cyc;
      bit          rdy;
      bit          seen;
      exp_t        e;
      logic [15:0] r;
      logic        dz;
      int          lat;
      @(negedge clk);
      out_ready = 1'b0;
      drive(4'd6, 16'hBEEF, 16'h0000);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== 16'hBEEF) begin
         errors++;
         $display("FAIL pre_reset_hold: got valid=%b result=%h, want 1/beef", out_valid, result);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || result !== 16'h0000 || div_zero !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_done: got valid=%b result=%h dz=%b, want 0/0000/0", out_valid, result, div_zero);
      end
      @(negedge clk);
      reset_n   = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      drive(4'd9, 16'd100, 16'd7);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || result !== 16'h0000 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_reset_busy: got valid=%b result=%h in_ready=%b, want 0/0000/1", out_valid, result, in_ready);
      end
      @(negedge clk);
      reset_n = 1'b1;
      seen    = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_result: out_valid seen=%b after reset, want 0", seen);
      end
      @(negedge clk);
      drive(4'd9, 16'd100, 16'd7);
      model(4'd9, 16'd100, 16'd7, r, dz, lat);
      sbq.push_back('{r, dz});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_valid(40, cyc, rdy);
      e = sbq.pop_front();
      checks++;
      if (cyc !== lat || result !== e.res || div_zero !== e.dz) begin
         errors++;
         $display("FAIL post_reset_divu: got %0d cycles result=%h dz=%b, want %0d/%h/%b",
                  cyc, result, div_zero, lat, e.res, e.dz);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_add_back_to_back();
      test_mul();
      test_op_sweep();
      test_div();
      test_rshfa_hold();
      test_flush();
      test_async_reset();
      checks++;
      if (sbq.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_empty: %0d entries left, want 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
